// File: rtl/fifo_drain_pkg.sv
// rtl/fifo_drain_pkg.sv - shared types and constants for the FIFO-to-UART drain
package fifo_drain_pkg;

    typedef enum logic [2:0] {
        FETCH_LO = 3'd0,
        FETCH_HI = 3'd1,
        START    = 3'd2,
        DATA     = 3'd3,
        STOP     = 3'd4
    } drain_state_e;

    localparam int UART_DATA_BITS  = 8;
    localparam int UART_FRAME_BITS = 10;

endpackage

// File: rtl/uart_bit_timer.sv
// rtl/uart_bit_timer.sv - baud counter that ticks on the last cycle of each bit period
module uart_bit_timer #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear_i,
    output logic tick_o
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Tick marks the final cycle of the current bit period.
    always_comb begin
        tick_o = (cnt_q == LAST_CNT);
        if (clear_i || tick_o) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Counter register; clear holds it at zero so the first bit period is full length.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/fifo_uart_drain.sv
// rtl/fifo_uart_drain.sv - pops nibble pairs from a FWFT FIFO and sends them as UART 8N1 bytes
module fifo_uart_drain
    import fifo_drain_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_WIDTH   = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic                  empty,
    input  logic [DATA_WIDTH-1:0] read_data,
    output logic                  read_increment,
    output logic                  tx,
    output logic                  busy,
    output logic [7:0]            frames_sent
);

    localparam int BYTE_W = 2 * DATA_WIDTH;
    localparam logic [2:0] LAST_BIT = 3'(UART_DATA_BITS - 1);

    drain_state_e      state_q;
    drain_state_e      state_d;
    logic [BYTE_W-1:0] shift_q;
    logic [BYTE_W-1:0] shift_d;
    logic [2:0]        bit_idx_q;
    logic [2:0]        bit_idx_d;
    logic              tx_q;
    logic              tx_d;
    logic              busy_q;
    logic              busy_d;
    logic [7:0]        frames_q;
    logic [7:0]        frames_d;

    logic lo_go;
    logic hi_go;
    logic timer_clear;
    logic bit_tick;

    assign lo_go = (state_q == FETCH_LO) && enable && !empty;
    assign hi_go = (state_q == FETCH_HI) && !empty;

    uart_bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_bit_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear_i(timer_clear),
        .tick_o (bit_tick)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FETCH_LO;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: fetch two nibbles, then walk start, eight data bits and stop.
    always_comb begin
        state_d = state_q;
        case (state_q)
            FETCH_LO: if (lo_go) state_d = FETCH_HI;
            FETCH_HI: if (hi_go) state_d = START;
            START:    if (bit_tick) state_d = DATA;
            DATA:     if (bit_tick && (bit_idx_q == LAST_BIT)) state_d = STOP;
            STOP:     if (bit_tick) state_d = FETCH_LO;
            default:  state_d = FETCH_LO;
        endcase
    end

    // Outputs and datapath next values; tx_d is the level for the coming cycle.
    always_comb begin
        read_increment = lo_go || hi_go;
        timer_clear    = (state_q == FETCH_LO) || (state_q == FETCH_HI);
        shift_d        = shift_q;
        bit_idx_d      = bit_idx_q;
        tx_d           = tx_q;
        busy_d         = busy_q;
        frames_d       = frames_q;
        case (state_q)
            FETCH_LO: begin
                tx_d = 1'b1;
                if (lo_go) begin
                    shift_d = {shift_q[BYTE_W-1:DATA_WIDTH], read_data};
                    busy_d  = 1'b1;
                end
            end
            FETCH_HI: begin
                tx_d = 1'b1;
                if (hi_go) begin
                    shift_d   = {read_data, shift_q[DATA_WIDTH-1:0]};
                    bit_idx_d = '0;
                    tx_d      = 1'b0;
                end
            end
            START: begin
                if (bit_tick) begin
                    tx_d = shift_q[0];
                end
            end
            DATA: begin
                if (bit_tick) begin
                    if (bit_idx_q == LAST_BIT) begin
                        tx_d = 1'b1;
                    end else begin
                        shift_d   = shift_q >> 1;
                        tx_d      = shift_q[1];
                        bit_idx_d = bit_idx_q + 1'b1;
                    end
                end
            end
            STOP: begin
                tx_d = 1'b1;
                if (bit_tick) begin
                    frames_d = frames_q + 1'b1;
                    busy_d   = 1'b0;
                end
            end
            default: begin
                tx_d = 1'b1;
            end
        endcase
    end

    // Datapath registers; tx comes straight from a flop so the line never glitches.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_q   <= '0;
            bit_idx_q <= '0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
            frames_q  <= '0;
        end else begin
            shift_q   <= shift_d;
            bit_idx_q <= bit_idx_d;
            tx_q      <= tx_d;
            busy_q    <= busy_d;
            frames_q  <= frames_d;
        end
    end

    assign tx          = tx_q;
    assign busy        = busy_q;
    assign frames_sent = frames_q;

endmodule
